sync_down_counter: RTL and testbench

Synchronous, loadable down counter with terminal-count pulse and optional auto-reload. It complements the ripple up counter: every bit is clocked by the single system clock, so all outputs change together on the clock edge with no ripple skew. It serves as the period/timeout generator beside the up counters in the counters library.

---
 rtl/sync_down_counter_pkg.sv | 12 +
 rtl/sync_down_counter_if.sv | 31 +++
 rtl/sync_down_counter_stage.sv | 28 ++
 rtl/sync_down_counter.sv | 102 ++++++++++
 tb/tb_sync_down_counter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/sync_down_counter_pkg.sv
// Shared definitions for the counters library: FSM state encodings and default width.
package counters_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sync_down_counter_if.sv
// Control/status bundle of the synchronous down counter, with FSM state exposed for observation.
interface sync_down_counter_if
    import counters_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    // No valid/ready pair: load is a single-cycle strobe taking priority over en,
    // and every status output is registered or decoded from registered state.
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic [WIDTH-1:0] Q;
    logic             zero;
    logic             tc;
    logic             busy;
    logic             done;
    state_t           dbg_state;

    modport master (
        output en, load, load_val, auto_reload,
        input  Q, zero, tc, busy, done, dbg_state
    );

    modport slave (
        input  en, load, load_val, auto_reload,
        output Q, zero, tc, busy, done, dbg_state
    );

endinterface

// File: rtl/sync_down_counter_stage.sv
// One counter bit: T flip-flop with async active-low reset and a synchronous load override.
module down_cnt_stage (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = ld ? d : (q_q ^ t);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sync_down_counter.sv
// Synchronous loadable down counter: FSM, reload register, tc register and borrow-chain decode.
module sync_down_counter
    import counters_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    sync_down_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] cnt_ld_val;
    state_t           state_q, state_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             run_step;
    logic             count_step;
    logic             cnt_ld;

    always_comb begin
        state_d    = state_q;
        reload_d   = reload_q;
        tc_d       = 1'b0;
        count_step = 1'b0;
        cnt_ld     = 1'b0;
        cnt_ld_val = bus.load_val;
        run_step   = (state_q == ST_RUN) && bus.en;
        if (bus.load) begin
            cnt_ld   = 1'b1;
            reload_d = bus.load_val;
            state_d  = (bus.load_val != '0) ? ST_RUN : ST_DONE;
        end else if (run_step) begin
            // Zero never decrements: it either reloads or ends the one-shot.
            if (q_w == '0) begin
                if (bus.auto_reload) begin
                    cnt_ld     = 1'b1;
                    cnt_ld_val = reload_q;
                end else begin
                    state_d = ST_DONE;
                end
            end else begin
                count_step = 1'b1;
                if (q_w == ONE) begin
                    tc_d = 1'b1;
                    if (!bus.auto_reload) begin
                        state_d = ST_DONE;
                    end
                end
            end
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Bit i flips on a decrement only when every lower bit is already 0.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign toggle[i] = count_step;
        end else begin : g_upper
            assign toggle[i] = count_step && (q_w[i-1:0] == '0);
        end

        down_cnt_stage u_stage (
            .clk   (clk),
            .rst_n (reset_n),
            .t     (toggle[i]),
            .ld    (cnt_ld),
            .d     (cnt_ld_val[i]),
            .q     (q_w[i])
        );
    end

    assign bus.Q         = q_w;
    assign bus.zero      = (q_w == '0);
    assign bus.tc        = tc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed self-checking bench for sync_down_counter (WIDTH=4).
module tb_sync_down_counter;

    logic clk;
    logic reset_n;
    int   pass_cnt;
    int   total_cnt;

    sync_down_counter_if #(.WIDTH(4)) bus ();

    sync_down_counter #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Advance one active edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [3:0] val, input logic ar, input logic en_v);
        bus.load        = 1'b1;
        bus.load_val    = val;
        bus.auto_reload = ar;
        bus.en          = en_v;
        step();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        bus.en          = 1'b0;
        bus.load        = 1'b0;
        bus.load_val    = 4'd0;
        bus.auto_reload = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        total_cnt++; if (bus.Q !== 4'd0) $display("FAIL reset_q got=%0d exp=0", bus.Q); else pass_cnt++;
        total_cnt++; if (bus.zero !== 1'b1) $display("FAIL reset_zero got=%b exp=1", bus.zero); else pass_cnt++;
        total_cnt++; if ({bus.tc, bus.busy, bus.done} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {bus.tc, bus.busy, bus.done}); else pass_cnt++;
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total_cnt++;
            if ({bus.Q, bus.zero, bus.tc, bus.busy} !== {4'd0, 3'b100})
                $display("FAIL idle_en_%0d got Q=%0d zero=%b tc=%b busy=%b exp Q=0 zero=1 tc=0 busy=0",
                         i, bus.Q, bus.zero, bus.tc, bus.busy);
            else pass_cnt++;
        end
        bus.en = 1'b0;
    endtask

    task automatic test_one_shot();
        logic [3:0] exp_q [4];
        logic       exp_tc [4];
        exp_q  = '{4'd3, 4'd2, 4'd1, 4'd0};
        exp_tc = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_load(4'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (bus.Q !== exp_q[i] || bus.tc !== exp_tc[i])
                $display("FAIL one_shot_%0d got Q=%0d tc=%b exp Q=%0d tc=%b", i, bus.Q, bus.tc, exp_q[i], exp_tc[i]);
            else pass_cnt++;
            if (i < 3) step();
        end
        total_cnt++; if ({bus.done, bus.busy, bus.zero} !== 3'b101)
            $display("FAIL one_shot_done got done/busy/zero=%b exp=101", {bus.done, bus.busy, bus.zero}); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if ({bus.Q, bus.tc, bus.done} !== {4'd0, 2'b01})
                $display("FAIL one_shot_hold_%0d got Q=%0d tc=%b done=%b exp Q=0 tc=0 done=1", i, bus.Q, bus.tc, bus.done);
            else pass_cnt++;
        end
        bus.en = 1'b0;
    endtask

    task automatic test_periodic();
        logic [3:0] exp_q [9];
        exp_q = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
        do_load(4'd2, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            total_cnt++;
            if (bus.Q !== exp_q[i] || bus.tc !== (i % 3 == 2) || bus.busy !== 1'b1)
                $display("FAIL periodic_%0d got Q=%0d tc=%b busy=%b exp Q=%0d tc=%b busy=1",
                         i, bus.Q, bus.tc, bus.busy, exp_q[i], (i % 3 == 2));
            else pass_cnt++;
            if (i < 8) step();
        end
        // Parked at 0 in RUN: clearing auto_reload ends the run without tc.
        bus.auto_reload = 1'b0;
        step();
        total_cnt++;
        if ({bus.Q, bus.tc, bus.busy, bus.done} !== {4'd0, 3'b001})
            $display("FAIL periodic_stop got Q=%0d tc=%b busy=%b done=%b exp Q=0 tc=0 busy=0 done=1",
                     bus.Q, bus.tc, bus.busy, bus.done);
        else pass_cnt++;
        bus.en = 1'b0;
    endtask

    task automatic test_load_priority();
        do_load(4'd7, 1'b0, 1'b0);
        bus.en = 1'b1;
        step();
        step();
        total_cnt++; if (bus.Q !== 4'd5) $display("FAIL lp_pre_q got=%0d exp=5", bus.Q); else pass_cnt++;
        do_load(4'd9, 1'b0, 1'b1);
        total_cnt++;
        if ({bus.Q, bus.tc, bus.busy} !== {4'd9, 2'b01})
            $display("FAIL lp_load got Q=%0d tc=%b busy=%b exp Q=9 tc=0 busy=1", bus.Q, bus.tc, bus.busy);
        else pass_cnt++;
        bus.en = 1'b0;
        step();
        total_cnt++; if (bus.Q !== 4'd9) $display("FAIL lp_hold got=%0d exp=9", bus.Q); else pass_cnt++;
    endtask

    task automatic test_en_toggle();
        logic [3:0] exp_q [5];
        logic       exp_tc [5];
        logic       en_seq [5];
        exp_q  = '{4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
        exp_tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        en_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_load(4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (bus.Q !== exp_q[i] || bus.tc !== exp_tc[i])
                $display("FAIL en_toggle_%0d got Q=%0d tc=%b exp Q=%0d tc=%b", i, bus.Q, bus.tc, exp_q[i], exp_tc[i]);
            else pass_cnt++;
            bus.en = en_seq[i];
            if (i < 4) step();
        end
        bus.en = 1'b0;
    endtask

    task automatic test_boundaries();
        do_load(4'd15, 1'b0, 1'b1);
        step();
        total_cnt++; if (bus.Q !== 4'd14) $display("FAIL max_dec got=%0d exp=14", bus.Q); else pass_cnt++;
        do_load(4'd8, 1'b0, 1'b1);
        step();
        total_cnt++; if (bus.Q !== 4'd7) $display("FAIL borrow_chain got=%0d exp=7", bus.Q); else pass_cnt++;
        do_load(4'd0, 1'b1, 1'b1);
        total_cnt++;
        if ({bus.Q, bus.tc, bus.busy, bus.done} !== {4'd0, 3'b001})
            $display("FAIL load_zero got Q=%0d tc=%b busy=%b done=%b exp Q=0 tc=0 busy=0 done=1",
                     bus.Q, bus.tc, bus.busy, bus.done);
        else pass_cnt++;
        bus.en = 1'b0;
    endtask

    task automatic test_async_reset();
        do_load(4'd8, 1'b0, 1'b1);
        step();
        step();
        bus.en = 1'b0;
        total_cnt++; if (bus.Q !== 4'd6) $display("FAIL ar_pre_q got=%0d exp=6", bus.Q); else pass_cnt++;
        #1 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.Q, bus.zero, bus.tc, bus.busy, bus.done} !== {4'd0, 4'b1000})
            $display("FAIL ar_immediate got Q=%0d zero=%b tc=%b busy=%b done=%b exp Q=0 zero=1 tc=0 busy=0 done=0",
                     bus.Q, bus.zero, bus.tc, bus.busy, bus.done);
        else pass_cnt++;
        #1 reset_n = 1'b1;
        @(negedge clk);
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if ({bus.Q, bus.busy} !== {4'd0, 1'b0})
                $display("FAIL ar_idle_%0d got Q=%0d busy=%b exp Q=0 busy=0", i, bus.Q, bus.busy);
            else pass_cnt++;
        end
        do_load(4'd4, 1'b0, 1'b1);
        total_cnt++;
        if ({bus.Q, bus.busy} !== {4'd4, 1'b1})
            $display("FAIL ar_reload got Q=%0d busy=%b exp Q=4 busy=1", bus.Q, bus.busy);
        else pass_cnt++;
        bus.en = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_one_shot();
        test_periodic();
        test_load_priority();
        test_en_toggle();
        test_boundaries();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
